// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the report UART: FSM state encoding,
//                frame geometry and the bit-period derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmitter FSM encoding (2-bit, kept as plain constants).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS = 8;

    // Clocks per serial bit; integer truncation (868 at 100 MHz / 115200).
    function automatic int calc_bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with an occupancy counter. Pushes while
//                full and pops while empty are ignored. Read data is the
//                head entry, presented combinationally.
//  Ports       : clk, rst_n (sync, active low), push/push_data,
//                pop/pop_data, full, empty, count (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_report_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_report_tx
//  Description : Buffered 8N1 UART transmitter for status reports. Bytes
//                arrive on a valid/ready port, are queued in sync_fifo and
//                are sent LSB first on tx_usb at BAUD_RATE.
//  Ports       : clk, rst_n (sync, active low)
//                tx_data/tx_valid/tx_ready - byte push port
//                tx_busy    - FIFO non-empty or frame in flight
//                fifo_level - bytes queued (0..FIFO_DEPTH)
//                tx_usb     - serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_report_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_usb
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ_HZ, BAUD_RATE);
    localparam int TW         = $clog2(BIT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CYCLES - 1);

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_done;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;

    // Ready is forced low during reset so no byte slips in on the reset edge.
    assign tx_ready  = rst_n && !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign bit_done  = (timer == TIMER_LAST);

    // Derived from registers only, so there is no path from tx_valid.
    assign tx_busy   = (state != ST_IDLE) || (fifo_level != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_usb  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_usb <= 1'b1;
                    timer  <= '0;
                    // The start bit goes out on the same edge as the pop.
                    if (!fifo_empty) begin
                        shift  <= fifo_dout;
                        state  <= ST_START;
                        tx_usb <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        tx_usb  <= shift[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state  <= ST_STOP;
                            tx_usb <= 1'b1;
                        end else begin
                            // shift[1] becomes shift[0] on this edge.
                            shift   <= shift >> 1;
                            tx_usb  <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_usb <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
